// File: rtl/xnor_serial_comparator.sv
// Serial word comparator fed by per-bit XNOR results; reports match, mismatch count, first mismatch index.
// Latency: start edge + WIDTH transfers; done held until res_ack, eq_bit stalls via eq_valid (eq_ready only in COLLECT).
module xnor_serial_comparator #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          eq_bit,
  input  logic          eq_valid,
  output logic          eq_ready,
  output logic          busy,
  output logic          done,
  input  logic          res_ack,
  output logic          match,
  output logic [CW-1:0] mismatch_cnt,
  output logic [CW-1:0] first_mismatch
);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] bit_idx_q, bit_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] first_q, first_d;
  logic          match_q, match_d;
  logic [CW-1:0] cnt_next;
  logic          xfer;

  assign xfer     = eq_valid && (state_q == COLLECT);
  assign cnt_next = eq_bit ? cnt_q : cnt_q + ONE_C;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    match_d   = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          bit_idx_d = '0;
          cnt_d     = '0;
          first_d   = WIDTH_C;
          match_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (xfer) begin
          bit_idx_d = bit_idx_q + ONE_C;
          cnt_d     = cnt_next;
          if (!eq_bit && (first_q == WIDTH_C)) begin
            first_d = bit_idx_q;
          end
          // Final bit: match must include this transfer, so use cnt_next.
          if (bit_idx_q == LAST_IDX) begin
            state_d   = REPORT;
            bit_idx_d = '0;
            match_d   = (cnt_next == '0);
          end
        end
      end
      REPORT: begin
        if (res_ack) begin
          if (start) begin
            state_d   = COLLECT;
            bit_idx_d = '0;
            cnt_d     = '0;
            first_d   = WIDTH_C;
            match_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      first_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      match_q   <= match_d;
    end
  end

  assign eq_ready       = (state_q == COLLECT);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == REPORT);
  assign match          = match_q;
  assign mismatch_cnt   = cnt_q;
  assign first_mismatch = first_q;

endmodule

// File: tb/tb_xnor_serial_comparator.sv
// Directed bench for xnor_serial_comparator: vector table of words plus hand sequences for latency, hold, back-to-back and reset.
module tb_xnor_serial_comparator;

  logic       clk = 1'b0;
  logic       rst_n, start, eq_bit, eq_valid, res_ack;
  logic       eq_ready, busy, done, match;
  logic [3:0] mismatch_cnt, first_mismatch;

  int n_checks = 0;
  int n_errors = 0;

  xnor_serial_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .eq_bit(eq_bit), .eq_valid(eq_valid),
    .eq_ready(eq_ready), .busy(busy), .done(done), .res_ack(res_ack), .match(match),
    .mismatch_cnt(mismatch_cnt), .first_mismatch(first_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] bits;
    logic [7:0] gaps;
    bit         idle_pulses;
    int         exp_match;
    int         exp_cnt;
    int         exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE and feeds one word LSB first; leaves the DUT in REPORT.
  task automatic send_word(input logic [7:0] bits, input logic [7:0] gaps, input bit idle_pulses);
    if (idle_pulses) begin
      eq_valid = 1'b1;
      eq_bit   = 1'b0;
      repeat (3) begin
        step();
        check("idle_eq_ready", int'(eq_ready), 0);
      end
      eq_valid = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        eq_valid = 1'b0;
        step();
      end
      eq_valid = 1'b1;
      eq_bit   = bits[i];
      step();
    end
    eq_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input int m, input int c, input int f);
    check({name, "_done"}, int'(done), 1);
    check({name, "_match"}, int'(match), m);
    check({name, "_cnt"}, int'(mismatch_cnt), c);
    check({name, "_first"}, int'(first_mismatch), f);
    check({name, "_rdy"}, int'(eq_ready), 0);
  endtask

  task automatic ack();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    check("ack_done", int'(done), 0);
    check("ack_busy", int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{"all_ones",  8'hFF, 8'h00, 1'b0, 1, 0, 8};
    vecs[1] = '{"pat_eb",    8'hEB, 8'h00, 1'b0, 0, 2, 2};
    vecs[2] = '{"pat_gaps",  8'hEB, 8'h26, 1'b1, 0, 2, 2};
    vecs[3] = '{"last_bit",  8'h7F, 8'h00, 1'b0, 0, 1, 7};
    vecs[4] = '{"all_zero",  8'h00, 8'h81, 1'b0, 0, 8, 0};
    vecs[5] = '{"first_bit", 8'hFE, 8'h00, 1'b1, 0, 1, 0};
    vecs[6] = '{"alt_55",    8'h55, 8'h10, 1'b0, 0, 4, 1};

    rst_n = 1'b0; start = 1'b0; eq_bit = 1'b0; eq_valid = 1'b0; res_ack = 1'b0;
    step();
    step();
    check("rst_eq_ready", int'(eq_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_match", int'(match), 0);
    check("rst_cnt", int'(mismatch_cnt), 0);
    check("rst_first", int'(first_mismatch), 0);
    rst_n = 1'b1;
    step();

    // Latency: done must appear exactly after the 9th edge counted from start.
    start = 1'b1;
    step();
    start = 1'b0;
    check("lat_rdy", int'(eq_ready), 1);
    for (int i = 0; i < 8; i++) begin
      check("lat_early_done", int'(done), 0);
      eq_valid = 1'b1;
      eq_bit   = 1'b1;
      step();
    end
    eq_valid = 1'b0;
    check_result("lat", 1, 0, 8);
    ack();

    for (int v = 0; v < 7; v++) begin
      send_word(vecs[v].bits, vecs[v].gaps, vecs[v].idle_pulses);
      check_result(vecs[v].name, vecs[v].exp_match, vecs[v].exp_cnt, vecs[v].exp_first);
      ack();
    end

    // Results hold while res_ack is low, then back-to-back start on the ack edge.
    send_word(8'hEB, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_result("hold", 0, 2, 2);
    end
    res_ack = 1'b1;
    start   = 1'b1;
    step();
    res_ack = 1'b0;
    start   = 1'b0;
    check("b2b_rdy", int'(eq_ready), 1);
    check("b2b_done", int'(done), 0);
    check("b2b_cnt_clr", int'(mismatch_cnt), 0);
    check("b2b_first_clr", int'(first_mismatch), 8);
    for (int i = 0; i < 8; i++) begin
      eq_valid = 1'b1;
      eq_bit   = 1'b0;
      step();
    end
    eq_valid = 1'b0;
    check_result("b2b", 0, 8, 0);
    ack();

    // Mid-word reset after three accepted bits, with eq_valid still high.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eq_valid = 1'b1;
      eq_bit   = 1'b0;
      step();
    end
    check("mid_cnt", int'(mismatch_cnt), 3);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    eq_valid = 1'b0;
    check("mid_rst_eq_ready", int'(eq_ready), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_match", int'(match), 0);
    check("mid_rst_cnt", int'(mismatch_cnt), 0);
    check("mid_rst_first", int'(first_mismatch), 0);
    send_word(8'hFF, 8'h00, 1'b0);
    check_result("post_rst", 1, 0, 8);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
